// File: rtl/nn_fp16_pkg.sv
// Shared fp16 constants and the ReLU-derivative sequencer state encoding.
package nn_fp16_pkg;

    localparam logic [15:0] FP16_ONE      = 16'h3C00;
    localparam logic [15:0] FP16_ZERO     = 16'h0000;
    localparam int unsigned FP16_SIGN_BIT = 32'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } relu_seq_state_t;

endpackage : nn_fp16_pkg

// File: rtl/relu_prime_stage.sv
// Result stage: turns each returning activation word into ReLU'(x) (or the
// fused gradient x ReLU'(x) when RELU_PRIME_GRAD_GATE_EN is defined) and
// queues it, with its source index, in a 2-entry FIFO whose head drives the
// output port.
module relu_prime_stage
    import nn_fp16_pkg::*;
#(
    parameter int unsigned       DATA_W  = 32'd16,
    parameter int unsigned       ADDR_W  = 32'd10,
    parameter logic [DATA_W-1:0] ONE_VAL = FP16_ONE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] act_data,
    input  logic [DATA_W-1:0] grad_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        count
);

    // Negative inputs (including -0) kill the value; everything else passes it.
    function automatic logic [DATA_W-1:0] relu_gate(input logic sign_bit,
                                                    input logic [DATA_W-1:0] pass_val);
        logic [DATA_W-1:0] res;
        if (sign_bit) begin
            res = {DATA_W{1'b0}};
        end else begin
            res = pass_val;
        end
        return res;
    endfunction

    logic [DATA_W-1:0] pass_s;
    logic [DATA_W-1:0] result_s;
    logic              unused_bits_s;
    logic              push_s;
    logic              pop_s;

    logic [DATA_W-1:0] mem_data_r [0:1];
    logic [ADDR_W-1:0] mem_addr_r [0:1];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        cnt_r;

`ifdef RELU_PRIME_GRAD_GATE_EN
    assign pass_s        = grad_data;
    assign unused_bits_s = ^act_data[DATA_W-2:0];
`else
    assign pass_s        = ONE_VAL;
    assign unused_bits_s = ^{act_data[DATA_W-2:0], grad_data};
`endif

    assign result_s = relu_gate(act_data[DATA_W-1], pass_s);

    // A full FIFO still accepts a word when the head leaves in the same cycle;
    // the sequencer's credit check keeps writes from ever exceeding that.
    assign pop_s  = (cnt_r != 2'd0) && rd_ready;
    assign push_s = wr_en && !flush && ((cnt_r != 2'd2) || pop_s);

    assign rd_valid = (cnt_r != 2'd0);
    assign rd_addr  = mem_addr_r[rd_ptr_r];
    assign rd_data  = mem_data_r[rd_ptr_r];
    assign count    = cnt_r;

    // FIFO storage, pointers and occupancy; flush empties and clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data_r[0] <= {DATA_W{1'b0}};
            mem_data_r[1] <= {DATA_W{1'b0}};
            mem_addr_r[0] <= {ADDR_W{1'b0}};
            mem_addr_r[1] <= {ADDR_W{1'b0}};
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            cnt_r         <= 2'd0;
        end else if (flush) begin
            mem_data_r[0] <= {DATA_W{1'b0}};
            mem_data_r[1] <= {DATA_W{1'b0}};
            mem_addr_r[0] <= {ADDR_W{1'b0}};
            mem_addr_r[1] <= {ADDR_W{1'b0}};
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            cnt_r         <= 2'd0;
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= result_s;
                mem_addr_r[wr_ptr_r] <= wr_addr;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule : relu_prime_stage

// File: rtl/relu_prime_seq.sv
// ReLU-derivative backprop sequencer. Walks len activation words from address
// 0, feeds the returning words through relu_prime_stage and streams results
// out with valid/ready backpressure.
// Optional feature macro: RELU_PRIME_GRAD_GATE_EN (fused gradient x ReLU').
//
// The issue decision is made in the same cycle as the read strobe and takes
// credit for the word leaving the FIFO in that cycle. That keeps the
// read-to-FIFO loop short enough for one element per cycle with only two
// FIFO entries while still guaranteeing the FIFO cannot overflow.
module relu_prime_seq
    import nn_fp16_pkg::*;
#(
    parameter int unsigned       DATA_W  = 32'd16,
    parameter int unsigned       ADDR_W  = 32'd10,
    parameter logic [DATA_W-1:0] ONE_VAL = FP16_ONE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              act_rd_en,
    output logic [ADDR_W-1:0] act_rd_addr,
    input  logic [DATA_W-1:0] act_rd_data,
    output logic              grad_rd_en,
    input  logic [DATA_W-1:0] grad_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    relu_seq_state_t   state_r;
    relu_seq_state_t   state_s;
    logic              busy_r;
    logic              done_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   issue_cnt_r;
    logic              ret_valid_r;
    logic [ADDR_W-1:0] ret_addr_r;

    logic [1:0]        fifo_cnt_s;
    logic              pop_s;
    logic [2:0]        occ_s;
    logic              issue_s;
    logic              last_issue_s;
    logic              drain_empty_s;

    // Words that will occupy the FIFO once this cycle's handshake completes:
    // entries already queued plus the word returning on the read bus.
    assign pop_s         = out_valid && out_ready;
    assign occ_s         = {1'b0, fifo_cnt_s} + {2'b00, ret_valid_r} - {2'b00, pop_s};
    assign issue_s       = (state_r == RUN) && !abort && (occ_s < 3'd2);
    assign last_issue_s  = issue_s && (issue_cnt_r == (len_r - {{ADDR_W{1'b0}}, 1'b1}));
    assign drain_empty_s = (occ_s == 3'd0);

    assign act_rd_en   = issue_s;
    assign act_rd_addr = issue_cnt_r[ADDR_W-1:0];
`ifdef RELU_PRIME_GRAD_GATE_EN
    assign grad_rd_en  = issue_s;
`else
    assign grad_rd_en  = 1'b0;
`endif
    assign busy = busy_r;
    assign done = done_r;

    // Next-state logic; abort wins over every transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (len == {(ADDR_W+1){1'b0}}) begin
                            state_s = DONE;
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (last_issue_s) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = RUN;
                    end
                end
                DRAIN: begin
                    if (drain_empty_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN) || (state_s == DRAIN);
            done_r  <= (state_s == DONE);
        end
    end

    // Pass length is captured only when a pass is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r <= {(ADDR_W+1){1'b0}};
        end else if ((state_r == IDLE) && start && !abort) begin
            len_r <= len;
        end
    end

    // Issue counter doubles as the read address; cleared around every pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_r <= {(ADDR_W+1){1'b0}};
        end else if (abort) begin
            issue_cnt_r <= {(ADDR_W+1){1'b0}};
        end else if ((state_r == IDLE) && start) begin
            issue_cnt_r <= {(ADDR_W+1){1'b0}};
        end else if (issue_s) begin
            issue_cnt_r <= issue_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
        end else if (state_r == DONE) begin
            issue_cnt_r <= {(ADDR_W+1){1'b0}};
        end
    end

    // Tracks the read whose data is on the bus this cycle; abort drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_valid_r <= 1'b0;
            ret_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            ret_valid_r <= issue_s;
            if (issue_s) begin
                ret_addr_r <= act_rd_addr;
            end
        end
    end

    relu_prime_stage #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ONE_VAL (ONE_VAL)
    ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .wr_en     (ret_valid_r),
        .wr_addr   (ret_addr_r),
        .act_data  (act_rd_data),
        .grad_data (grad_rd_data),
        .rd_ready  (out_ready),
        .rd_valid  (out_valid),
        .rd_addr   (out_addr),
        .rd_data   (out_data),
        .count     (fifo_cnt_s)
    );

endmodule : relu_prime_seq

// File: tb/tb_relu_prime_seq.sv
// Directed, table-driven bench for relu_prime_seq. Cycle 0 is the cycle in
// which start is driven high. Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_relu_prime_seq;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              act_rd_en;
    logic [ADDR_W-1:0] act_rd_addr;
    logic [DATA_W-1:0] act_rd_data;
    logic              grad_rd_en;
    logic [DATA_W-1:0] grad_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    relu_prime_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .act_rd_en    (act_rd_en),
        .act_rd_addr  (act_rd_addr),
        .act_rd_data  (act_rd_data),
        .grad_rd_en   (grad_rd_en),
        .grad_rd_data (grad_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    // Activation / gradient memories with one-cycle registered read.
    logic [DATA_W-1:0] act_mem  [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] grad_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (act_rd_en) begin
            act_rd_data  <= act_mem[act_rd_addr];
            grad_rd_data <= grad_mem[act_rd_addr];
        end
    end

    typedef struct {
        logic [15:0] act;
        logic [15:0] grad;
        logic [15:0] exp_plain;
        logic [15:0] exp_gate;
    } vec_t;
    vec_t tbl [0:11];

    int n_cmp = 0;
    int n_bad = 0;

    int cyc, ready_mode, abort_at, restart_at;
    int issued, accepted, max_out, first_valid, done_cnt, done_cyc, last_hs;
    int busy_seen, busy_at_done, addr_err, grad_err, post_abort, timeout;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] got_data[$];
    logic [ADDR_W-1:0] got_addr[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_of(input int i);
`ifdef RELU_PRIME_GRAD_GATE_EN
        return tbl[i].exp_gate;
`else
        return tbl[i].exp_plain;
`endif
    endfunction

    task automatic check_reset_outs(input string name);
        check(name, {busy, done, act_rd_en, grad_rd_en, out_valid, act_rd_addr, out_addr, out_data}, 64'd0);
    endtask

    // One clock cycle: drive this cycle's inputs, then sample at mid-cycle.
    task automatic run_cycle(input logic st);
        @(posedge clk);
        #1;
        cyc++;
        start = st;
        abort = (cyc == abort_at);
        if (cyc == restart_at) begin
            start = 1'b1;
            len   = 11'd3;
        end
        if (ready_mode == 0) out_ready = 1'b1;
        else                 out_ready = (((cyc + 3) % 3) == 0);
        @(negedge clk);
        if (prev_stall) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, prev_data);
            check("hold_addr", out_addr, prev_addr);
        end
        if ((issued - accepted) > max_out) max_out = issued - accepted;
        if (act_rd_en) begin
            if (act_rd_addr != ADDR_W'(issued)) addr_err++;
            issued++;
        end
`ifdef RELU_PRIME_GRAD_GATE_EN
        if (grad_rd_en !== act_rd_en) grad_err++;
`else
        if (grad_rd_en !== 1'b0) grad_err++;
`endif
        if (abort_at >= 0 && cyc == abort_at + 1)
            check("abort_idle", {busy, out_valid, act_rd_en, done}, 64'd0);
        if (abort_at >= 0 && cyc > abort_at && (act_rd_en || out_valid)) post_abort++;
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_addr.push_back(out_addr);
            accepted++;
            last_hs = cyc;
        end
        if (busy) busy_seen++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) busy_at_done++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_addr  = out_addr;
    endtask

    task automatic do_pass(input int n, input int base, input int mode, input int ab_at, input int rs_at);
        for (int i = 0; i < n; i++) begin
            act_mem[i]  = tbl[(base + i) % 12].act;
            grad_mem[i] = tbl[(base + i) % 12].grad;
        end
        issued = 0; accepted = 0; max_out = 0; first_valid = -1; done_cnt = 0;
        done_cyc = -1; last_hs = -1; busy_seen = 0; busy_at_done = 0; addr_err = 0;
        grad_err = 0; post_abort = 0; timeout = 1; prev_stall = 1'b0;
        got_data.delete(); got_addr.delete();
        ready_mode = mode; abort_at = ab_at; restart_at = rs_at;
        len = (ADDR_W+1)'(n);
        cyc = -1;
        run_cycle(1'b1);
        for (int k = 0; k < 300; k++) begin
            run_cycle(1'b0);
            if (done_cnt != 0 || (ab_at >= 0 && cyc >= ab_at + 10)) begin
                timeout = 0;
                break;
            end
        end
        repeat (3) run_cycle(1'b0);
        check("timeout", timeout, 0);
        check("grad_rd_en", grad_err, 0);
        check("addr_order", addr_err, 0);
    endtask

    task automatic check_results(input int n, input int base);
        check("n_results", got_data.size(), n);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            check($sformatf("res_addr[%0d]", i), got_addr[i], i);
            check($sformatf("res_data[%0d]", i), got_data[i], exp_of((base + i) % 12));
        end
        check("done_count", done_cnt, 1);
        check("done_after_last_hs", done_cyc, last_hs + 1);
        check("busy_at_done", busy_at_done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16'h3C00, 16'h1111, 16'h3C00, 16'h1111};
        tbl[1]  = '{16'hBC00, 16'h2222, 16'h0000, 16'h0000};
        tbl[2]  = '{16'h0000, 16'h3333, 16'h3C00, 16'h3333};
        tbl[3]  = '{16'h8000, 16'h4444, 16'h0000, 16'h0000};
        tbl[4]  = '{16'h4000, 16'h3555, 16'h3C00, 16'h3555};
        tbl[5]  = '{16'hC000, 16'h1234, 16'h0000, 16'h0000};
        tbl[6]  = '{16'h7BFF, 16'hABCD, 16'h3C00, 16'hABCD};
        tbl[7]  = '{16'hFBFF, 16'h0001, 16'h0000, 16'h0000};
        tbl[8]  = '{16'h0001, 16'h8001, 16'h3C00, 16'h8001};
        tbl[9]  = '{16'h8001, 16'h7FFF, 16'h0000, 16'h0000};
        tbl[10] = '{16'h7C00, 16'h0F0F, 16'h3C00, 16'h0F0F};
        tbl[11] = '{16'hFC00, 16'hFFFF, 16'h0000, 16'h0000};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = 11'd0; out_ready = 1'b0;
        ready_mode = 0; abort_at = -100; restart_at = -100; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // len=4 at full throughput
        do_pass(4, 0, 0, -100, -100);
        check_results(4, 0);
        check("first_valid_cycle", first_valid, 3);
        check("done_cycle_len4", done_cyc, 7);

        // len=0: immediate done, no reads, never busy
        do_pass(0, 0, 0, -100, -100);
        check("len0_done_cycle", done_cyc, 1);
        check("len0_done_count", done_cnt, 1);
        check("len0_reads", issued, 0);
        check("len0_busy", busy_seen, 0);

        // len=8 with out_ready 1,0,0,1,...
        do_pass(8, 4, 1, -100, -100);
        check_results(8, 4);
        check("max_outstanding_ok", (max_out <= 2), 1'b1);

        // abort at cycle 4 of a len=16 pass, then a clean len=2 pass
        do_pass(16, 0, 0, 4, -100);
        check("abort_no_done", done_cnt, 0);
        check("abort_quiet_after", post_abort, 0);
        do_pass(2, 4, 0, -100, -100);
        check_results(2, 4);
        check("first_valid_after_abort", first_valid, 3);
        check("done_cycle_len2", done_cyc, 5);

        // start (with a different len) while busy is ignored
        do_pass(8, 0, 0, -100, 3);
        check_results(8, 0);
        check("done_cycle_restart", done_cyc, 11);

        // asynchronous reset in the middle of a pass
        for (int i = 0; i < 8; i++) act_mem[i] = tbl[i].act;
        ready_mode = 0; abort_at = -100; restart_at = -100;
        len = 11'd8;
        cyc = -1;
        run_cycle(1'b1);
        repeat (4) run_cycle(1'b0);
        check("busy_before_reset", busy, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid_pass_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_pass(4, 0, 0, -100, -100);
        check_results(4, 0);
        check("done_cycle_after_reset", done_cyc, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_relu_prime_seq
